// File: rtl/key_sched_ctrl_128.sv
// AES-128 key schedule controller: pops a cipher key, then alternates emitting
// round keys to the consumer and round-tripping them through the expansion stage.
module key_sched_ctrl_128 #(
    parameter int unsigned NR = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [127:0] in_key_i,
    input  logic         in_key_empty_i,
    output logic         in_key_rd_o,
    output logic [127:0] exp_key_o,
    output logic [7:0]   exp_rc_o,
    input  logic         exp_key_full_i,
    input  logic         exp_rc_full_i,
    output logic         exp_key_wr_o,
    output logic         exp_rc_wr_o,
    input  logic [127:0] exp_res_i,
    input  logic         exp_res_empty_i,
    output logic         exp_res_rd_o,
    output logic [127:0] out_rkey_o,
    output logic [3:0]   out_round_o,
    input  logic         out_rkey_full_i,
    output logic         out_rkey_wr_o,
    output logic         busy_o,
    output logic         key_done_o
);

    typedef enum logic [1:0] {IDLE, EMIT, ISSUE, WAIT} state_e;

    localparam logic [3:0] NR_L = 4'(NR);

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rc_q, rc_d;
    logic         exp_push;
    logic         last_round;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    assign last_round = (round_q == NR_L);

    // Strobes are gated by reset so they fall the instant reset asserts.
    always_comb begin
        in_key_rd_o   = 1'b0;
        out_rkey_wr_o = 1'b0;
        exp_push      = 1'b0;
        exp_res_rd_o  = 1'b0;
        if (rst_ni) begin
            unique case (state_q)
                IDLE:    in_key_rd_o   = !in_key_empty_i;
                EMIT:    out_rkey_wr_o = !out_rkey_full_i;
                ISSUE:   exp_push      = !exp_key_full_i && !exp_rc_full_i;
                WAIT:    exp_res_rd_o  = !exp_res_empty_i;
                default: ;
            endcase
        end
    end

    assign exp_key_wr_o = exp_push;
    assign exp_rc_wr_o  = exp_push;
    assign key_done_o   = out_rkey_wr_o && last_round;
    assign busy_o       = (state_q != IDLE);

    assign exp_key_o   = key_q;
    assign exp_rc_o    = rc_q;
    assign out_rkey_o  = key_q;
    assign out_round_o = round_q;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rc_d    = rc_q;
        unique case (state_q)
            IDLE: begin
                if (in_key_rd_o) begin
                    key_d   = in_key_i;
                    round_d = 4'd0;
                    rc_d    = 8'h01;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (out_rkey_wr_o) begin
                    state_d = last_round ? IDLE : ISSUE;
                end
            end
            ISSUE: begin
                if (exp_push) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (exp_res_rd_o) begin
                    key_d   = exp_res_i;
                    round_d = round_q + 4'd1;
                    rc_d    = xtime(rc_q);
                    state_d = EMIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            rc_q    <= 8'h01;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rc_q    <= rc_d;
        end
    end

endmodule

// File: tb/tb_key_sched_ctrl_128.sv
// Bench for key_sched_ctrl_128: AES-128 expansion-stage model plus an
// ordered transaction scoreboard derived from the key schedule.
module tb_key_sched_ctrl_128;

    localparam int EV_W = 0;
    localparam int EV_I = 1;
    localparam int EV_R = 2;

    typedef struct {
        int           kind;
        logic [127:0] key;
        logic [7:0]   rc;
        int           rnd;
        bit           done;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n         [2];
    logic [127:0] in_key        [2];
    logic         in_key_empty  [2];
    logic         in_key_rd     [2];
    logic [127:0] exp_key       [2];
    logic [7:0]   exp_rc        [2];
    logic         exp_key_full  [2];
    logic         exp_rc_full   [2];
    logic         exp_key_wr    [2];
    logic         exp_rc_wr     [2];
    logic [127:0] exp_res       [2];
    logic         exp_res_empty [2];
    logic         exp_res_rd    [2];
    logic [127:0] out_rkey      [2];
    logic [3:0]   out_round     [2];
    logic         out_rkey_full [2];
    logic         out_rkey_wr   [2];
    logic         busy          [2];
    logic         key_done      [2];

    key_sched_ctrl_128 #(.NR(10)) u0 (
        .clk_i(clk), .rst_ni(rst_n[0]),
        .in_key_i(in_key[0]), .in_key_empty_i(in_key_empty[0]),
        .in_key_rd_o(in_key_rd[0]),
        .exp_key_o(exp_key[0]), .exp_rc_o(exp_rc[0]),
        .exp_key_full_i(exp_key_full[0]), .exp_rc_full_i(exp_rc_full[0]),
        .exp_key_wr_o(exp_key_wr[0]), .exp_rc_wr_o(exp_rc_wr[0]),
        .exp_res_i(exp_res[0]), .exp_res_empty_i(exp_res_empty[0]),
        .exp_res_rd_o(exp_res_rd[0]),
        .out_rkey_o(out_rkey[0]), .out_round_o(out_round[0]),
        .out_rkey_full_i(out_rkey_full[0]), .out_rkey_wr_o(out_rkey_wr[0]),
        .busy_o(busy[0]), .key_done_o(key_done[0])
    );

    key_sched_ctrl_128 #(.NR(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n[1]),
        .in_key_i(in_key[1]), .in_key_empty_i(in_key_empty[1]),
        .in_key_rd_o(in_key_rd[1]),
        .exp_key_o(exp_key[1]), .exp_rc_o(exp_rc[1]),
        .exp_key_full_i(exp_key_full[1]), .exp_rc_full_i(exp_rc_full[1]),
        .exp_key_wr_o(exp_key_wr[1]), .exp_rc_wr_o(exp_rc_wr[1]),
        .exp_res_i(exp_res[1]), .exp_res_empty_i(exp_res_empty[1]),
        .exp_res_rd_o(exp_res_rd[1]),
        .out_rkey_o(out_rkey[1]), .out_round_o(out_round[1]),
        .out_rkey_full_i(out_rkey_full[1]), .out_rkey_wr_o(out_rkey_wr[1]),
        .busy_o(busy[1]), .key_done_o(key_done[1])
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] sbox_t [256];
    logic [7:0] rcon [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    ev_t          evq [$];
    logic [127:0] srcq [$];
    logic [127:0] res_val;
    bit           res_pend, res_avail;
    int           st_out, st_key, st_rc, st_res, pct;
    int           sel, nr_cur, cyc;
    int           done_cnt, done_round, n_wr;
    logic [127:0] wr_log [11];
    logic [7:0]   rc_log [$];
    int           pop_cyc [$];
    int           w0_cyc [$];
    bit           busy_log [$];
    bit           l_out, l_exp, l_rd, l_res;
    int           l_round;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] bswap(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
        return r;
    endfunction

    // Next AES-128 round key; byte i of the key lives at bits [8i+7:8i].
    function automatic logic [127:0] next_key(input logic [127:0] k,
                                              input logic [7:0] rc);
        logic [7:0]   t [4];
        logic [127:0] n;
        t[0] = sbox_t[k[111:104]] ^ rc;
        t[1] = sbox_t[k[119:112]];
        t[2] = sbox_t[k[127:120]];
        t[3] = sbox_t[k[103:96]];
        for (int j = 0; j < 4; j++) n[8*j +: 8] = k[8*j +: 8] ^ t[j];
        for (int i = 4; i < 16; i++) n[8*i +: 8] = k[8*i +: 8] ^ n[8*(i-4) +: 8];
        return n;
    endfunction

    task automatic plan_key(input logic [127:0] k);
        logic [127:0] rk;
        ev_t e;
        rk = k;
        for (int r = 0; r <= nr_cur; r++) begin
            e.kind = EV_W; e.key = rk; e.rc = 8'h00; e.rnd = r; e.done = (r == nr_cur);
            evq.push_back(e);
            if (r < nr_cur) begin
                e.kind = EV_I; e.rc = rcon[r]; e.done = 1'b0;
                evq.push_back(e);
                e.kind = EV_R;
                evq.push_back(e);
                rk = next_key(rk, rcon[r]);
            end
        end
    endtask

    task automatic take(input int kind, output ev_t e);
        chk("ev_present", evq.size() != 0, 1);
        if (evq.size() != 0) begin
            e = evq.pop_front();
            chk("ev_kind", e.kind, kind);
        end else begin
            e.kind = -1; e.key = '0; e.rc = '0; e.rnd = -1; e.done = 1'b0;
        end
    endtask

    task automatic idle_inputs(input int s);
        in_key_empty[s]  = 1'b1;
        exp_res_empty[s] = 1'b1;
        out_rkey_full[s] = 1'b1;
        exp_key_full[s]  = 1'b1;
        exp_rc_full[s]   = 1'b1;
    endtask

    task automatic hot_inputs(input int s);
        in_key_empty[s]  = 1'b0;
        exp_res_empty[s] = 1'b0;
        out_rkey_full[s] = 1'b0;
        exp_key_full[s]  = 1'b0;
        exp_rc_full[s]   = 1'b0;
        in_key[s]        = {$urandom(), $urandom(), $urandom(), $urandom()};
        exp_res[s]       = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic chk_reset(input int s);
        chk("rst_busy", busy[s], 0);
        chk("rst_done", key_done[s], 0);
        chk("rst_in_rd", in_key_rd[s], 0);
        chk("rst_out_wr", out_rkey_wr[s], 0);
        chk("rst_key_wr", exp_key_wr[s], 0);
        chk("rst_rc_wr", exp_rc_wr[s], 0);
        chk("rst_res_rd", exp_res_rd[s], 0);
        chk("rst_out_rkey", out_rkey[s], 0);
        chk("rst_exp_key", exp_key[s], 0);
        chk("rst_out_round", out_round[s], 0);
        chk("rst_exp_rc", exp_rc[s], 8'h01);
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 11; i++) wr_log[i] = '0;
        rc_log.delete();
        n_wr = 0;
    endtask

    task automatic cycle();
        int  s;
        int  ns;
        ev_t e;
        logic [127:0] k;
        s = sel;
        @(negedge clk);
        in_key_empty[s] = (srcq.size() == 0);
        if (srcq.size() != 0) in_key[s] = srcq[0];
        else in_key[s] = {$urandom(), $urandom(), $urandom(), $urandom()};
        out_rkey_full[s] = (st_out > 0) || (int'($urandom_range(99)) < pct);
        exp_key_full[s]  = (st_key > 0) || (int'($urandom_range(99)) < pct);
        exp_rc_full[s]   = (st_rc > 0) || (int'($urandom_range(99)) < pct);
        exp_res_empty[s] = !res_avail || (st_res > 0) || (int'($urandom_range(99)) < pct);
        if (res_avail) exp_res[s] = res_val;
        else exp_res[s] = {$urandom(), $urandom(), $urandom(), $urandom()};
        #1;
        l_rd = in_key_rd[s];
        l_out = out_rkey_wr[s];
        l_exp = exp_key_wr[s];
        l_res = exp_res_rd[s];
        l_round = int'(out_round[s]);
        ns = int'(l_rd) + int'(l_out) + int'(l_exp) + int'(l_res);
        chk("one_strobe", ns <= 1, 1);
        chk("wr_pair", exp_rc_wr[s], exp_key_wr[s]);
        chk("busy", busy[s], evq.size() != 0);
        chk("flag_gate", (l_rd && in_key_empty[s]) || (l_out && out_rkey_full[s]) ||
            (l_exp && (exp_key_full[s] || exp_rc_full[s])) ||
            (l_res && exp_res_empty[s]), 0);
        chk("done_wo_wr", key_done[s] && !l_out, 0);
        if (l_rd) begin
            chk("rd_when_idle", evq.size(), 0);
            k = srcq.pop_front();
            plan_key(k);
            pop_cyc.push_back(cyc);
        end
        if (l_out) begin
            take(EV_W, e);
            if (e.kind == EV_W) begin
                chk("rkey", out_rkey[s], e.key);
                chk("round", out_round[s], e.rnd);
                chk("key_done", key_done[s], e.done);
            end
            if (l_round < 11) wr_log[l_round] = out_rkey[s];
            if (l_round == 0) w0_cyc.push_back(cyc);
            n_wr++;
        end
        if (l_exp) begin
            take(EV_I, e);
            if (e.kind == EV_I) begin
                chk("exp_key", exp_key[s], e.key);
                chk("exp_rc", exp_rc[s], e.rc);
            end
            rc_log.push_back(exp_rc[s]);
            res_val = next_key(exp_key[s], exp_rc[s]);
            res_pend = 1'b1;
        end
        if (l_res) begin
            take(EV_R, e);
            res_avail = 1'b0;
        end
        if (key_done[s]) begin
            done_cnt++;
            done_round = l_round;
        end
        busy_log.push_back(busy[s]);
        cyc++;
        @(posedge clk);
        if (res_pend) begin
            res_avail = 1'b1;
            res_pend = 1'b0;
        end
        if (st_out > 0) st_out--;
        if (st_key > 0) st_key--;
        if (st_rc > 0) st_rc--;
        if (st_res > 0) st_res--;
    endtask

    task automatic run_done(input int n, input int budget);
        int tgt;
        tgt = done_cnt + n;
        while (done_cnt < tgt && budget > 0) begin
            cycle();
            budget--;
        end
        chk("run_done_timeout", done_cnt >= tgt, 1);
    endtask

    task automatic run_until(input int kind, input int rnd, input int budget);
        while (!(evq.size() != 0 && evq[0].kind == kind && evq[0].rnd == rnd)
               && budget > 0) begin
            cycle();
            budget--;
        end
        chk("run_until_timeout", budget > 0, 1);
    endtask

    initial begin
        logic [127:0] golden;
        logic [127:0] r1_exp;
        logic [127:0] r10_exp;
        int p0, p1, nidle;

        golden  = bswap(128'h2b7e151628aed2a6abf7158809cf4f3c);
        r1_exp  = bswap(128'ha0fafe1788542cb123a339392a6c7605);
        r10_exp = bswap(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        st_out = 0; st_key = 0; st_rc = 0; st_res = 0; pct = 0;
        sel = 0; nr_cur = 10; cyc = 0; done_cnt = 0; done_round = -1;
        res_pend = 1'b0; res_avail = 1'b0; res_val = '0;
        clear_logs();

        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        hot_inputs(0);
        hot_inputs(1);
        #12;
        chk_reset(0);
        chk_reset(1);
        idle_inputs(0);
        idle_inputs(1);
        @(negedge clk);
        rst_n[0] = 1'b1;

        // Golden vector
        srcq.push_back(golden);
        run_done(1, 100);
        chk("gold_nwr", n_wr, 11);
        chk("gold_r0", wr_log[0], golden);
        chk("gold_r1", wr_log[1], r1_exp);
        chk("gold_r10", wr_log[10], r10_exp);
        chk("gold_done_round", done_round, 10);
        chk("gold_nrc", rc_log.size(), 10);
        for (int i = 0; i < 10 && i < rc_log.size(); i++) chk("gold_rc", rc_log[i], rcon[i]);
        chk("latency", w0_cyc[w0_cyc.size()-1] - pop_cyc[pop_cyc.size()-1], 1);

        // Back-to-back keys
        srcq.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        srcq.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        run_done(2, 200);
        p1 = pop_cyc[pop_cyc.size()-1];
        p0 = pop_cyc[pop_cyc.size()-2];
        chk("tput_gap", p1 - p0, 32);
        nidle = 0;
        for (int c = p0 + 1; c <= p1; c++) if (!busy_log[c]) nidle++;
        chk("tput_idle", nidle, 1);

        // Backpressure on each interface
        srcq.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        run_until(EV_W, 3, 200);
        st_out = 5;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_out_hold", l_out, 0);
            chk("bp_out_round", l_round, 3);
        end
        cycle();
        chk("bp_out_rel", l_out, 1);
        run_until(EV_I, 4, 200);
        st_rc = 3;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("split_hold", l_exp, 0);
        end
        cycle();
        chk("split_rel", l_exp, 1);
        run_until(EV_I, 5, 200);
        st_key = 5;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_key_hold", l_exp, 0);
        end
        cycle();
        chk("bp_key_rel", l_exp, 1);
        run_until(EV_R, 6, 200);
        st_res = 5;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_res_hold", l_res, 0);
        end
        cycle();
        chk("bp_res_rel", l_res, 1);
        run_done(1, 200);

        // Random backpressure soak
        pct = 30;
        for (int i = 0; i < 4; i++)
            srcq.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        run_done(4, 2000);
        pct = 0;

        // Reset during round-5 WAIT
        srcq.push_back(golden);
        run_until(EV_R, 5, 200);
        #2;
        rst_n[0] = 1'b0;
        hot_inputs(0);
        #1;
        chk_reset(0);
        evq.delete();
        srcq.delete();
        res_avail = 1'b0;
        res_pend = 1'b0;
        idle_inputs(0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        clear_logs();
        srcq.push_back(golden);
        run_done(1, 100);
        chk("rst_nwr", n_wr, 11);
        chk("rst_r0", wr_log[0], golden);
        chk("rst_r10", wr_log[10], r10_exp);
        chk("rst_rc0", rc_log.size() != 0 ? rc_log[0] : 8'h00, 8'h01);

        // NR = 1 instance
        sel = 1;
        nr_cur = 1;
        clear_logs();
        @(negedge clk);
        rst_n[1] = 1'b1;
        srcq.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
        run_done(1, 100);
        chk("nr1_nwr", n_wr, 2);
        chk("nr1_done_round", done_round, 1);
        chk("nr1_nrc", rc_log.size(), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_sched_ctrl_128.md
KEY_SCHED_CTRL_128 -- requirements
Module: key_sched_ctrl_128

Interface
REQ-001 Parameter NR, default 10, number of expansion rounds per key; legal range 1..10.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_key  input  128  cipher key; byte i at bits [8i+7:8i], byte 0 is the first key byte.
REQ-005 in_key_empty  input  1  source FIFO has no key.
REQ-006 in_key_rd  output  1  pop strobe for the source key FIFO.
REQ-007 exp_key  output  128  current round key sent to the expansion stage.
REQ-008 exp_rc  output  8  round constant sent to the expansion stage.
REQ-009 exp_key_full, exp_rc_full  input  1 each  expansion-stage input FIFOs cannot accept data.
REQ-010 exp_key_wr, exp_rc_wr  output  1 each  push strobes to the expansion stage.
REQ-011 exp_res  input  128  next round key returned by the expansion stage.
REQ-012 exp_res_empty  input  1  expansion-stage result FIFO has no data.
REQ-013 exp_res_rd  output  1  pop strobe for the expansion-stage result.
REQ-014 out_rkey  output  128  round key to the consumer.
REQ-015 out_round  output  4  index of out_rkey, 0..NR.
REQ-016 out_rkey_full  input  1  consumer FIFO cannot accept data.
REQ-017 out_rkey_wr  output  1  push strobe to the consumer.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 key_done  output  1  one-cycle pulse coincident with the write of round NR.

Function
REQ-020 FSM states: IDLE, EMIT, ISSUE, WAIT. Registers: key_q (128), round_q (4), rc_q (8).
REQ-021 FIFO convention: a strobe is asserted only when the matching empty/full flag is low. A strobe high at a clock edge means the transfer completes on that edge.
REQ-022 All strobes and key_done are combinational from state and flags. All data outputs are driven from registers.
REQ-023 IDLE: in_key_rd = !in_key_empty. On a pop: key_q <= in_key, round_q <= 0, rc_q <= 8'h01, next state EMIT.
REQ-024 EMIT: out_rkey = key_q, out_round = round_q, out_rkey_wr = !out_rkey_full. The FSM stalls while out_rkey_full is high.
REQ-025 EMIT, on a write: if round_q == NR, key_done = 1 and next state IDLE; otherwise next state ISSUE.
REQ-026 ISSUE: exp_key = key_q, exp_rc = rc_q.
REQ-027 ISSUE: exp_key_wr and exp_rc_wr are both high only when exp_key_full and exp_rc_full are both low. The two strobes are never asserted separately. On the push, next state WAIT.
REQ-028 WAIT: exp_res_rd = !exp_res_empty. On a pop: key_q <= exp_res, round_q <= round_q+1, rc_q <= xtime(rc_q), next state EMIT.
REQ-029 xtime(x) = {x[6:0],1'b0} XOR (x[7] ? 8'h1b : 8'h00). Sequence: 01,02,04,08,10,20,40,80,1b,36.
REQ-030 Latency: out_rkey_wr is first possible in the cycle after the in_key pop.
REQ-031 Unstalled, one key takes 1+(NR+1)+2*NR cycles (32 for NR=10). The next key can be popped in the cycle after key_done.
REQ-032 Outside their active state, exp_key and out_rkey hold key_q, and exp_rc holds rc_q. They never go X.
REQ-033 At most one strobe (counting the exp_*_wr pair as one) is high in any cycle.
REQ-034 Input flag changes in non-matching states have no effect. The controller never pops exp_res before issuing.

Reset
REQ-035 While reset is low: state = IDLE; key_q = 0; round_q = 0; rc_q = 8'h01; all strobes, busy and key_done = 0.
REQ-036 Reset asserted mid-sequence abandons the key immediately. No further strobes occur. Any result left in the expansion stage is the integrator's responsibility to flush.
REQ-037 After release, the first action is an in_key pop in IDLE.

Verification
REQ-038 Golden: bench models the expansion stage as full AES-128 next-round-key with 1-cycle latency. Input in_key bytes 2b7e151628aed2a6abf7158809cf4f3c (byte0 = 2b). Expected: 11 writes, out_round 0..10. Round 1 = a0fafe1788542cb123a339392a6c7605. Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6. key_done with round 10 only. Observed exp_rc sequence = 01..36.
REQ-039 Throughput: two keys queued, no stalls. Second in_key_rd occurs exactly 32 cycles after the first, and busy drops for exactly that one IDLE cycle.
REQ-040 Backpressure: out_rkey_full held high for 5 cycles during round 3. No write occurs during the hold, out_round stays 3, and the write occurs on the first cycle full is low. Same check with exp_key_full high for 5 cycles in ISSUE and exp_res_empty high for 5 cycles in WAIT.
REQ-041 Split flags: exp_rc_full high with exp_key_full low results in no exp_*_wr.
REQ-042 Reset mid-op: reset low during round 5 WAIT. All outputs are at reset values asynchronously (before the next clock edge). After release with the golden key queued, the full 11-key sequence restarts from round 0 with exp_rc = 01.
REQ-043 NR=1: exactly 2 writes, rounds 0 and 1, with key_done on round 1.
